// File: rtl/auc_pkg.sv
// Shared definitions for the auc_* phase controllers: ALU opcodes, the RAM
// address map and the final-sequencer state encoding.
package auc_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_INV  = 4'b0010;
  localparam logic [3:0] OP_EXP  = 4'b0011;
  localparam logic [3:0] OP_SWAP = 4'b0100;
  localparam logic [3:0] OP_FA   = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;

  localparam int ADDR_X2   = 7;
  localparam int ADDR_Z2   = 8;
  localparam int ADDR_X3   = 9;
  localparam int ADDR_Z3   = 10;
  localparam int ADDR_OUT  = 15;
  localparam int ADDR_IDLE = 18;
  localparam int ADDR_TMP  = 20;
  localparam int ADDR_JUNK = 30;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'd0,
    ST_SZ_R0    = 5'd1,
    ST_SZ_R1    = 5'd2,
    ST_SZ_WAIT  = 5'd3,
    ST_SZ_W0    = 5'd4,
    ST_SZ_W1    = 5'd5,
    ST_SX_R0    = 5'd6,
    ST_SX_R1    = 5'd7,
    ST_SX_WAIT  = 5'd8,
    ST_SX_W0    = 5'd9,
    ST_SX_W1    = 5'd10,
    ST_INV_R    = 5'd11,
    ST_INV_WAIT = 5'd12,
    ST_INV_WR   = 5'd13,
    ST_MUL_R0   = 5'd14,
    ST_MUL_R1   = 5'd15,
    ST_MUL_WAIT = 5'd16,
    ST_MUL_WR   = 5'd17,
    ST_DONE     = 5'd18,
    ST_ERR      = 5'd19
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == ST_SZ_WAIT) || (s == ST_SX_WAIT) ||
           (s == ST_INV_WAIT) || (s == ST_MUL_WAIT);
  endfunction

endpackage

// File: rtl/auc_byterev.sv
// Combinational byte reversal: byte i of the output is byte (N-1-i) of the input.
module auc_byterev #(
  parameter int WID = 256
) (
  input  logic [WID-1:0] din,
  output logic [WID-1:0] dout
);

  for (genvar i = 0; i < WID / 8; i++) begin : g_byte
    assign dout[8*i +: 8] = din[WID-1-8*i -: 8];
  end

endmodule

// File: rtl/auc_ladder_final_seq.sv
// Final-stage sequencer of the Montgomery ladder: optional (X,Z) swap, Z2
// inversion, X2*Z2^-1 and result write-back, with a per-wait watchdog.
module auc_ladder_final_seq
  import auc_pkg::*;
#(
  parameter int WID    = 256,
  parameter int AWID   = 5,
  parameter int OPWID  = 4,
  parameter int TMOW   = 12,
  parameter int A_X2   = ADDR_X2,
  parameter int A_Z2   = ADDR_Z2,
  parameter int A_X3   = ADDR_X3,
  parameter int A_Z3   = ADDR_Z3,
  parameter int A_TMP  = ADDR_TMP,
  parameter int A_OUT  = ADDR_OUT,
  parameter int A_IDLE = ADDR_IDLE,
  parameter int A_JUNK = ADDR_JUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             final_en,
  input  logic             final_cswap,
  input  logic             final_bswap,
  input  logic             final_auvld,
  input  logic [WID-1:0]   final_audat,
  input  logic [WID-1:0]   final_aurswap,
  output logic             final_busy,
  output logic             final_done,
  output logic             final_err,
  output logic [OPWID-1:0] final_opcode,
  output logic             final_auen,
  output logic             final_swapvl,
  output logic [AWID-1:0]  final_ra,
  output logic [AWID-1:0]  final_wa,
  output logic             final_we,
  output logic [WID-1:0]   final_wd
);

  localparam logic [AWID-1:0]  AD_X2   = AWID'(A_X2);
  localparam logic [AWID-1:0]  AD_Z2   = AWID'(A_Z2);
  localparam logic [AWID-1:0]  AD_X3   = AWID'(A_X3);
  localparam logic [AWID-1:0]  AD_Z3   = AWID'(A_Z3);
  localparam logic [AWID-1:0]  AD_TMP  = AWID'(A_TMP);
  localparam logic [AWID-1:0]  AD_OUT  = AWID'(A_OUT);
  localparam logic [AWID-1:0]  AD_IDLE = AWID'(A_IDLE);
  localparam logic [AWID-1:0]  AD_JUNK = AWID'(A_JUNK);
  localparam logic [OPWID-1:0] OPC_SWAP = OPWID'(OP_SWAP);
  localparam logic [OPWID-1:0] OPC_INV  = OPWID'(OP_INV);
  localparam logic [OPWID-1:0] OPC_MUL  = OPWID'(OP_MUL);

  state_t          state, state_nx;
  logic            cswap_q, bswap_q;
  logic [WID-1:0]  res0, res1, res0_rev;
  logic [TMOW-1:0] wdog;
  logic            in_wait, wd_expired;

  logic             busy_d, done_d, err_d, auen_d, swapvl_d, we_d;
  logic [OPWID-1:0] opcode_d;
  logic [AWID-1:0]  ra_d, wa_d;
  logic [WID-1:0]   wd_d;

  auc_byterev #(.WID(WID)) u_byterev (
    .din  (res0),
    .dout (res0_rev)
  );

  assign in_wait    = is_wait(state);
  assign wd_expired = (wdog == {TMOW{1'b1}});

  // A WAIT state exits on auvld; otherwise an all-ones watchdog aborts to ERR.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (final_en) state_nx = final_cswap ? ST_SZ_R0 : ST_INV_R;
      ST_SZ_R0:    state_nx = ST_SZ_R1;
      ST_SZ_R1:    state_nx = ST_SZ_WAIT;
      ST_SZ_WAIT:  if (final_auvld) state_nx = ST_SZ_W0;
                   else if (wd_expired) state_nx = ST_ERR;
      ST_SZ_W0:    state_nx = ST_SZ_W1;
      ST_SZ_W1:    state_nx = ST_SX_R0;
      ST_SX_R0:    state_nx = ST_SX_R1;
      ST_SX_R1:    state_nx = ST_SX_WAIT;
      ST_SX_WAIT:  if (final_auvld) state_nx = ST_SX_W0;
                   else if (wd_expired) state_nx = ST_ERR;
      ST_SX_W0:    state_nx = ST_SX_W1;
      ST_SX_W1:    state_nx = ST_INV_R;
      ST_INV_R:    state_nx = ST_INV_WAIT;
      ST_INV_WAIT: if (final_auvld) state_nx = ST_INV_WR;
                   else if (wd_expired) state_nx = ST_ERR;
      ST_INV_WR:   state_nx = ST_MUL_R0;
      ST_MUL_R0:   state_nx = ST_MUL_R1;
      ST_MUL_R1:   state_nx = ST_MUL_WAIT;
      ST_MUL_WAIT: if (final_auvld) state_nx = ST_MUL_WR;
                   else if (wd_expired) state_nx = ST_ERR;
      ST_MUL_WR:   state_nx = ST_DONE;
      ST_DONE:     state_nx = ST_IDLE;
      ST_ERR:      state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Output decode of the current state; registered below, so it shows up a cycle later.
  always_comb begin
    busy_d   = 1'b1;
    done_d   = 1'b0;
    err_d    = 1'b0;
    auen_d   = 1'b0;
    swapvl_d = 1'b0;
    we_d     = 1'b0;
    opcode_d = '0;
    ra_d     = AD_IDLE;
    wa_d     = AD_JUNK;
    wd_d     = '0;
    case (state)
      ST_IDLE:   busy_d = 1'b0;
      ST_SZ_R0:  ra_d = AD_Z2;
      ST_SZ_R1:  begin
        ra_d = AD_Z3; auen_d = 1'b1; swapvl_d = 1'b1; opcode_d = OPC_SWAP;
      end
      ST_SZ_W0:  begin wa_d = AD_Z2; wd_d = res0; we_d = 1'b1; end
      ST_SZ_W1:  begin wa_d = AD_Z3; wd_d = res1; we_d = 1'b1; end
      ST_SX_R0:  ra_d = AD_X2;
      ST_SX_R1:  begin
        ra_d = AD_X3; auen_d = 1'b1; swapvl_d = 1'b1; opcode_d = OPC_SWAP;
      end
      ST_SX_W0:  begin wa_d = AD_X2; wd_d = res0; we_d = 1'b1; end
      ST_SX_W1:  begin wa_d = AD_X3; wd_d = res1; we_d = 1'b1; end
      ST_INV_R:  begin ra_d = AD_Z2; auen_d = 1'b1; opcode_d = OPC_INV; end
      ST_INV_WR: begin wa_d = AD_TMP; wd_d = res0; we_d = 1'b1; end
      ST_MUL_R0: ra_d = AD_X2;
      ST_MUL_R1: begin ra_d = AD_TMP; auen_d = 1'b1; opcode_d = OPC_MUL; end
      ST_MUL_WR: begin
        wa_d = AD_OUT; wd_d = bswap_q ? res0_rev : res0; we_d = 1'b1;
      end
      ST_DONE:   begin busy_d = 1'b0; done_d = 1'b1; end
      ST_ERR:    begin busy_d = 1'b0; err_d = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cswap_q      <= 1'b0;
      bswap_q      <= 1'b0;
      res0         <= '0;
      res1         <= '0;
      wdog         <= '0;
      final_busy   <= 1'b0;
      final_done   <= 1'b0;
      final_err    <= 1'b0;
      final_auen   <= 1'b0;
      final_swapvl <= 1'b0;
      final_we     <= 1'b0;
      final_opcode <= '0;
      final_ra     <= AD_IDLE;
      final_wa     <= AD_JUNK;
      final_wd     <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && final_en) begin
        cswap_q <= final_cswap;
        bswap_q <= final_bswap;
      end
      if (in_wait && final_auvld) begin
        res0 <= final_audat;
        res1 <= final_aurswap;
      end
      // WAIT states are never adjacent, so entry is simply "next is WAIT, current is not".
      if (is_wait(state_nx) && !in_wait) wdog <= '0;
      else if (in_wait)                  wdog <= wdog + TMOW'(1);
      final_busy   <= busy_d;
      final_done   <= done_d;
      final_err    <= err_d;
      final_auen   <= auen_d;
      final_swapvl <= swapvl_d;
      final_we     <= we_d;
      final_opcode <= opcode_d;
      final_ra     <= ra_d;
      final_wa     <= wa_d;
      final_wd     <= wd_d;
    end
  end

endmodule
